// File: rtl/life_gen_scheduler.sv
// Row-scan timebase and generation sequencer for the 8x8 Game of Life datapath.
// Seed loads and generation steps are only issued on the cycle after a frame boundary.
module life_gen_scheduler #(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned ROW_W          = 3,
  parameter int unsigned ROW_TICKS      = 4,
  parameter int unsigned FRAMES_PER_GEN = 2,
  parameter int unsigned GEN_W          = 16,
  parameter bit          RUN_AT_RESET   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_toggle,
  input  logic             step_req,
  input  logic             seed_req,
  output logic [ROW_W-1:0] row_sel,
  output logic             row_tick,
  output logic             frame_end,
  output logic             load_seed,
  output logic             step_en,
  output logic             running,
  output logic [GEN_W-1:0] gen_count
);

  localparam int unsigned DIV_W = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam int unsigned FC_W  = $clog2(FRAMES_PER_GEN + 1);

  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_STEP} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ROW_W-1:0] row_sel_q, row_sel_d;
  logic             row_tick_q, row_tick_d;
  logic             frame_end_q, frame_end_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             seed_pend_q, seed_pend_d;
  logic             step_pend_q, step_pend_d;
  logic             running_q, running_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             load_seed_q, load_seed_d;
  logic             step_en_q, step_en_d;
  logic             enter_load, enter_step, step_set;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q + DIV_W'(1);
    row_sel_d   = row_sel_q;
    row_tick_d  = 1'b0;
    frame_end_d = 1'b0;
    fc_d        = fc_q;
    running_d   = running_q ^ run_toggle;
    gen_d       = gen_q;
    step_set    = step_req & ~running_q;

    // Row scan: advance row_sel together with the row_tick pulse.
    if (div_q == DIV_W'(ROW_TICKS - 1)) begin
      div_d      = '0;
      row_tick_d = 1'b1;
      if (row_sel_q == ROW_W'(ROWS - 1)) begin
        row_sel_d   = '0;
        frame_end_d = 1'b1;
      end else begin
        row_sel_d = row_sel_q + ROW_W'(1);
      end
    end

    unique case (state_q)
      S_WAIT: begin
        if (frame_end_q) begin
          if (seed_pend_q)      state_d = S_LOAD;
          else if (step_pend_q) state_d = S_STEP;
        end
      end
      default: state_d = S_WAIT;
    endcase

    enter_load  = (state_d == S_LOAD);
    enter_step  = (state_d == S_STEP);
    load_seed_d = enter_load;
    step_en_d   = enter_step;

    // Generation timer only runs while free-running; a load or resume restarts it.
    if (enter_load || (run_toggle && !running_q)) begin
      fc_d = '0;
    end else if (frame_end_q && running_q) begin
      if (fc_q == FC_W'(FRAMES_PER_GEN - 1)) begin
        fc_d     = '0;
        step_set = 1'b1;
      end else begin
        fc_d = fc_q + FC_W'(1);
      end
    end

    // New requests win over the clear so a request on a boundary cycle is kept for the next one.
    seed_pend_d = seed_req | (seed_pend_q & ~enter_load);
    step_pend_d = step_set | (step_pend_q & ~(enter_load | enter_step));

    if (enter_load)      gen_d = '0;
    else if (enter_step) gen_d = gen_q + GEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_WAIT;
      div_q       <= '0;
      row_sel_q   <= '0;
      row_tick_q  <= 1'b0;
      frame_end_q <= 1'b0;
      fc_q        <= '0;
      seed_pend_q <= 1'b1;
      step_pend_q <= 1'b0;
      running_q   <= RUN_AT_RESET;
      gen_q       <= '0;
      load_seed_q <= 1'b0;
      step_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      row_sel_q   <= row_sel_d;
      row_tick_q  <= row_tick_d;
      frame_end_q <= frame_end_d;
      fc_q        <= fc_d;
      seed_pend_q <= seed_pend_d;
      step_pend_q <= step_pend_d;
      running_q   <= running_d;
      gen_q       <= gen_d;
      load_seed_q <= load_seed_d;
      step_en_q   <= step_en_d;
    end
  end

  assign row_sel   = row_sel_q;
  assign row_tick  = row_tick_q;
  assign frame_end = frame_end_q;
  assign load_seed = load_seed_q;
  assign step_en   = step_en_q;
  assign running   = running_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Randomized scoreboard bench for life_gen_scheduler: default instance plus a GEN_W=2 instance.
module tb_life_gen_scheduler;

  localparam int ROWS  = 8;
  localparam int RT    = 4;
  localparam int FPG   = 2;
  localparam int FRAME = ROWS * RT;

  typedef struct packed {
    logic [2:0]  row;
    logic        tick;
    logic        fe;
    logic        load;
    logic        step;
    logic        run;
    logic [15:0] gen;
  } exp_t;

  logic clk = 1'b1;
  logic rst = 1'b0;
  logic run_toggle = 1'b0, step_req = 1'b0, seed_req = 1'b0;

  logic [2:0]  row_sel, row_sel2;
  logic        row_tick, frame_end, load_seed, step_en, running;
  logic        row_tick2, frame_end2, load_seed2, step_en2, running2;
  logic [15:0] gen_count;
  logic [1:0]  gen_count2;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];

  // Reference model state: time is counted in clock edges since reset release.
  int   m_t = 0;
  bit   m_run = 1, m_seed = 1, m_spend = 0, m_fe = 0, m_step = 0;
  int   m_fc = 0;
  int   m_gen = 0;

  always #5 clk = ~clk;

  life_gen_scheduler dut (
    .clk(clk), .rst(rst), .run_toggle(run_toggle), .step_req(step_req), .seed_req(seed_req),
    .row_sel(row_sel), .row_tick(row_tick), .frame_end(frame_end), .load_seed(load_seed),
    .step_en(step_en), .running(running), .gen_count(gen_count)
  );

  life_gen_scheduler #(.GEN_W(2)) dut_g2 (
    .clk(clk), .rst(rst), .run_toggle(run_toggle), .step_req(step_req), .seed_req(seed_req),
    .row_sel(row_sel2), .row_tick(row_tick2), .frame_end(frame_end2), .load_seed(load_seed2),
    .step_en(step_en2), .running(running2), .gen_count(gen_count2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, expv);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic [2:0] rs, input logic rt,
                           input logic fe, input logic ld, input logic st, input logic rn,
                           input logic [15:0] g, input logic [15:0] gmask);
    chk({tag, ".row_sel"},   32'(rs), 32'(e.row));
    chk({tag, ".row_tick"},  32'(rt), 32'(e.tick));
    chk({tag, ".frame_end"}, 32'(fe), 32'(e.fe));
    chk({tag, ".load_seed"}, 32'(ld), 32'(e.load));
    chk({tag, ".step_en"},   32'(st), 32'(e.step));
    chk({tag, ".running"},   32'(rn), 32'(e.run));
    chk({tag, ".gen_count"}, 32'(g),  32'(e.gen & gmask));
    chk({tag, ".load_and_step"}, 32'(ld & st), 32'(0));
  endtask

  // Predict the outputs after the next rising edge given the inputs held during this cycle.
  task automatic model_step(input logic rstv, input logic rt, input logic sq, input logic sr);
    exp_t e;
    bit do_load, do_step, set;
    if (!rstv) begin
      m_t = 0; m_run = 1; m_seed = 1; m_spend = 0; m_fe = 0; m_fc = 0; m_gen = 0; m_step = 0;
      e = '0;
      e.run = 1'b1;
    end else begin
      do_load = m_fe && m_seed;
      do_step = m_fe && !m_seed && m_spend;
      set = sq && !m_run;
      if (do_load || (rt && !m_run)) m_fc = 0;
      else if (m_fe && m_run) begin
        m_fc++;
        if (m_fc == FPG) begin m_fc = 0; set = 1; end
      end
      m_seed  = sr || (m_seed && !do_load);
      m_spend = set || (m_spend && !(do_load || do_step));
      if (do_load) m_gen = 0;
      else if (do_step) m_gen = (m_gen + 1) % 65536;
      m_run = m_run ^ rt;
      m_t++;
      m_fe   = (m_t % FRAME) == 0;
      m_step = do_step;
      e.row  = 3'((m_t / RT) % ROWS);
      e.tick = (m_t % RT) == 0;
      e.fe   = m_fe;
      e.load = do_load;
      e.step = do_step;
      e.run  = m_run;
      e.gen  = 16'(m_gen);
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic rstv, input logic rt, input logic sq, input logic sr);
    @(negedge clk);
    rst = rstv; run_toggle = rt; step_req = sq; seed_req = sr;
    model_step(rstv, rt, sq, sr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard_underrun at %0t: got empty queue expected an entry", $time);
      end else begin
        e = q.pop_front();
        check_dut("dut", e, row_sel, row_tick, frame_end, load_seed, step_en, running,
                  gen_count, 16'hFFFF);
        check_dut("dut_g2", e, row_sel2, row_tick2, frame_end2, load_seed2, step_en2, running2,
                  16'(gen_count2), 16'h0003);
      end
    end
  end

  initial begin : driver
    int waited;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(6 * FRAME);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4 * FRAME);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(4);
    end
    idle(2 * FRAME);

    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    idle(3 * FRAME);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    waited = 0;
    while (!m_step && waited < 300) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      waited++;
    end
    chk("step_before_reset_seen", 32'(m_step), 32'(1));

    // Pull reset mid-cycle while step_en is high; outputs must clear without a clock edge.
    @(negedge clk);
    rst = 1'b0; run_toggle = 1'b0; step_req = 1'b0; seed_req = 1'b0;
    #1;
    chk("async_rst.row_sel",   32'(row_sel),   32'(0));
    chk("async_rst.row_tick",  32'(row_tick),  32'(0));
    chk("async_rst.frame_end", 32'(frame_end), 32'(0));
    chk("async_rst.load_seed", 32'(load_seed), 32'(0));
    chk("async_rst.step_en",   32'(step_en),   32'(0));
    chk("async_rst.step_en2",  32'(step_en2),  32'(0));
    chk("async_rst.running",   32'(running),   32'(1));
    chk("async_rst.gen_count", 32'(gen_count), 32'(0));
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(12 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      cyc(1'b1, 1'(($urandom % 40) == 0), 1'(($urandom % 30) == 0), 1'(($urandom % 50) == 0));
    end
    idle(2 * FRAME);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/life_gen_scheduler.md
Name: life_gen_scheduler

Overview:
Sequencer for the 8x8 Game of Life datapath: owns the LED row-scan timebase and decides when the cell array loads its seed pattern or advances one generation. All grid updates are deferred to a frame boundary (after the last row is scanned) so the display never shows a half-updated grid. Sits between the button front-end (debounced single-cycle pulses) and the cell array / row-column driver inside main.

Parameters:
ROWS, 8, rows in the LED matrix / grid
ROW_W, 3, width of row_sel, equal to clog2(ROWS)
ROW_TICKS, 4, clk cycles each row is displayed; minimum 2
FRAMES_PER_GEN, 2, full display frames per generation while running; minimum 1
GEN_W, 16, width of generation counter
RUN_AT_RESET, 1, value of running after reset

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
run_toggle  input  1  one-cycle pulse: flip run/pause
step_req  input  1  one-cycle pulse: request single generation step (honoured only while paused)
seed_req  input  1  one-cycle pulse: request reload of seed pattern
row_sel  output  ROW_W  row currently driven to the matrix
row_tick  output  1  one-cycle pulse when row_sel advances
frame_end  output  1  one-cycle pulse on the row_tick that wraps row_sel ROWS-1 -> 0
load_seed  output  1  one-cycle command: cell array loads seed
step_en  output  1  one-cycle command: cell array computes next generation
running  output  1  1 = free-running, 0 = paused
gen_count  output  GEN_W  generations since last seed load, wraps modulo 2^GEN_W

Behaviour:
- Reset (rst=0, async): row_sel=0, row_tick=0, frame_end=0, load_seed=0, step_en=0, gen_count=0, running=RUN_AT_RESET, internal dividers=0, pending flags cleared except seed_pend=1, FSM=WAIT.
- Scan timebase: row divider counts 0..ROW_TICKS-1 every cycle in all FSM states. On terminal count: row_tick=1 next cycle, row_sel increments mod ROWS in that same cycle. frame_end=1 on the row_tick where row_sel goes ROWS-1 -> 0. First row_tick occurs ROW_TICKS cycles after reset release. One frame = ROWS*ROW_TICKS cycles.
- Generation timer: frame counter increments on frame_end only while running=1; on reaching FRAMES_PER_GEN it clears and sets step_pend. Counter cleared when running goes 0->1 and on any load.
- Requests (sampled every cycle):
  - seed_req sets seed_pend.
  - step_req while running=0 sets step_pend; ignored while running=1. Multiple step_req before the next frame_end collapse into one step.
  - run_toggle flips running next cycle; going 1->0 does not cancel an already-set step_pend.
- FSM states WAIT, LOAD, STEP:
  - WAIT: on frame_end=1, if seed_pend -> LOAD; else if step_pend -> STEP; else stay.
  - LOAD: load_seed=1 for exactly this cycle; clears seed_pend and step_pend; gen_count=0; frame counter=0 -> WAIT.
  - STEP: step_en=1 for exactly this cycle; clears step_pend; gen_count+1 (wraps) -> WAIT.
  - load_seed/step_en therefore assert in the cycle after frame_end, coinciding with row 0 display; never both in the same cycle.
- Priority: seed beats step; a step pending at a load is discarded. seed_req and run_toggle in the same cycle both take effect.
- A request arriving in the same cycle as frame_end is not serviced at that boundary; it is serviced at the next frame_end.
- Reset mid-operation: all outputs return to reset values immediately (async), including mid-pulse load_seed/step_en; the seed is reloaded at the first frame_end after release.

Test Plan:
- Reset release, defaults -> row_tick every 4 cycles; row_sel 0..7 repeating; frame_end every 32 cycles; load_seed single pulse in cycle after first frame_end; gen_count=0; running=1.
- Free run 5 frames after load -> step_en one cycle after 3rd and 5th frame_end counted from load; gen_count 1 then 2; never co-asserted with load_seed.
- run_toggle -> running=0; no further step_en for 4 frames; step_req x3 within one frame -> exactly one step_en after next frame_end, gen_count+1.
- step_req and seed_req in same cycle while paused -> only load_seed at next boundary, gen_count=0, no step_en at following frame_end.
- Drive rst=0 mid-frame during a step_en cycle -> all outputs 0 asynchronously, row_sel=0; after release load_seed repeats at first frame_end.
- GEN_W=2, run 5 generations -> gen_count 1,2,3,0,1.
